// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/LSU memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } own_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way grant picker; grant[0] = IF, grant[1] = LS (one-hot or zero).
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_valid,
    input  logic       ls_valid,
    input  own_e       last,
    input  logic       rr_en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (if_valid && ls_valid) begin
            // Round-robin hands the slot to whoever was not granted last; otherwise LS wins.
            grant = (rr_en && (last == OWN_LS)) ? 2'b01 : 2'b10;
        end else if (if_valid) begin
            grant = 2'b01;
        end else if (ls_valid) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IF and LSU, one transaction in flight at a time.
// Define ARB_RR_EN for round-robin contention; the default build gives the LSU fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_wen,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);

    localparam int MASK_W = DATA_W / 8;

    state_e              state_q, state_d;
    own_e                own_q, own_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                if_rv_q, if_rv_d;
    logic                ls_rv_q, ls_rv_d;
    logic [1:0]          grant;
    logic                can_accept;
    own_e                pick_last;

`ifdef ARB_RR_EN
    localparam logic RR_EN = 1'b1;
    own_e last_q, last_d;
    assign pick_last = last_q;
`else
    localparam logic RR_EN = 1'b0;
    assign pick_last = OWN_LS;
`endif

    mem_arb_pick u_pick (
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .last     (pick_last),
        .rr_en    (RR_EN),
        .grant    (grant)
    );

    // Hold off acceptance during the response pulse so the next grant lands a cycle later.
    assign can_accept   = reset_n && (state_q == IDLE) && !if_rv_q && !ls_rv_q;
    assign if_req_ready = can_accept && grant[0];
    assign ls_req_ready = can_accept && grant[1];

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        if_rv_d = 1'b0;
        ls_rv_d = 1'b0;
`ifdef ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (can_accept && (grant != 2'b00)) begin
                    if (grant[1]) begin
                        own_d   = OWN_LS;
                        addr_d  = ls_req_addr;
                        wen_d   = ls_req_wen;
                        wdata_d = ls_req_wdata;
                        wmask_d = ls_req_wmask;
                    end else begin
                        own_d   = OWN_IF;
                        addr_d  = if_req_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
`ifdef ARB_RR_EN
                    last_d  = own_d;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                    if (own_q == OWN_LS) begin
                        ls_rv_d = 1'b1;
                        rdata_d = wen_q ? '0 : mem_resp_data;
                    end else begin
                        if_rv_d = 1'b1;
                        rdata_d = mem_resp_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            own_q   <= OWN_IF;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            if_rv_q <= 1'b0;
            ls_rv_q <= 1'b0;
`ifdef ARB_RR_EN
            last_q  <= OWN_LS;
`endif
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            if_rv_q <= if_rv_d;
            ls_rv_q <= ls_rv_d;
`ifdef ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign if_resp_valid = if_rv_q;
    assign ls_resp_valid = ls_rv_q;
    assign if_resp_data  = rdata_q;
    assign ls_resp_data  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single IF read, contention, stalled LSU write,
// spurious and post-reset responses, and a 10-deep contention run.
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req_valid = 1'b0;
    logic          if_req_ready;
    logic [AW-1:0] if_req_addr = '0;
    logic          if_resp_valid;
    logic [DW-1:0] if_resp_data;
    logic          ls_req_valid = 1'b0;
    logic          ls_req_ready;
    logic [AW-1:0] ls_req_addr = '0;
    logic          ls_req_wen = 1'b0;
    logic [DW-1:0] ls_req_wdata = '0;
    logic [MW-1:0] ls_req_wmask = '0;
    logic          ls_resp_valid;
    logic [DW-1:0] ls_resp_data;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b1;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wen;
    logic [DW-1:0] mem_req_wdata;
    logic [MW-1:0] mem_req_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_rdata = '0;

    logic auto_en = 1'b1;
    logic auto_resp = 1'b0;
    logic man_resp = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int if_pulses = 0;
    int ls_pulses = 0;
    int mem_hs = 0;
    logic [DW-1:0] if_last = '0;
    logic [DW-1:0] ls_last = '0;
    int gq[$];
    int b_if, b_ls, b_hs;

    assign mem_resp_valid = auto_resp | man_resp;

    mem_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wen    (ls_req_wen),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_wmask  (ls_req_wmask),
        .ls_resp_valid (ls_resp_valid),
        .ls_resp_data  (ls_resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1, "watchdog expired");
    end

    // Memory model: answers one cycle after a request handshake.
    always begin
        @(negedge clk);
        if (mem_req_valid && mem_req_ready && auto_en) begin
            @(posedge clk); #1 auto_resp = 1'b1;
            @(posedge clk); #1 auto_resp = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (if_resp_valid) begin if_pulses++; if_last = if_resp_data; end
        if (ls_resp_valid) begin ls_pulses++; ls_last = ls_resp_data; end
        if (mem_req_valid && mem_req_ready) mem_hs++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Each requester issues up to its count; grants are logged in order (0 = IF, 1 = LS).
    task automatic run_both(input int if_n, input int ls_n, input int total);
        int if_left;
        int ls_left;
        int cyc;
        if_left = if_n;
        ls_left = ls_n;
        cyc = 0;
        gq.delete();
        while (gq.size() < total && cyc < 400) begin
            @(posedge clk); #1;
            if_req_valid = (if_left > 0);
            ls_req_valid = (ls_left > 0);
            @(negedge clk);
            cyc++;
            if (if_req_valid && if_req_ready) begin gq.push_back(0); if_left--; end
            if (ls_req_valid && ls_req_ready) begin gq.push_back(1); ls_left--; end
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("grant_count", 64'(gq.size()), 64'(total));
    endtask

    initial begin
        // Reset with both requests pending: every output must stay 0
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0004;
        @(posedge clk);
        @(negedge clk);
        chk("rst_if_ready", if_req_ready, 0);
        chk("rst_ls_ready", ls_req_ready, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_resp_valid", {if_resp_valid, ls_resp_valid}, 0);
        chk("rst_mem_addr", mem_req_addr, 0);
        chk("rst_wen_mask", {mem_req_wen, mem_req_wmask}, 0);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // IF alone, 3-cycle latency, single pulse, no acceptance during the pulse
        b_if = if_pulses; b_ls = ls_pulses;
        mem_rdata    = 64'h1111_2222_3333_4444;
        if_req_addr  = 64'h8000_0004;
        if_req_valid = 1'b1;
        #1;
        chk("a_if_ready", if_req_ready, 1);
        chk("a_ls_ready", ls_req_ready, 0);
        @(posedge clk); #1 if_req_valid = 1'b0;
        @(negedge clk);
        chk("a_issue_valid", mem_req_valid, 1);
        chk("a_issue_addr", mem_req_addr, 64'h8000_0004);
        chk("a_issue_wen_mask", {mem_req_wen, mem_req_wmask}, 0);
        @(posedge clk); #1;
        chk("a_wait_mem_valid", mem_req_valid, 0);
        chk("a_wait_no_resp", if_resp_valid, 0);
        @(posedge clk); #1;
        chk("a_if_resp_valid", if_resp_valid, 1);
        chk("a_if_resp_data", if_resp_data, 64'h1111_2222_3333_4444);
        chk("a_ls_resp_quiet", ls_resp_valid, 0);
        if_req_valid = 1'b1;
        #1;
        chk("a_busy_ready", if_req_ready, 0);
        @(posedge clk); #1;
        chk("a_pulse_width", if_resp_valid, 0);
        chk("a_reaccept", if_req_ready, 1);
        @(posedge clk); #1 if_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("a_if_pulses", 64'(if_pulses - b_if), 2);
        chk("a_ls_pulses", 64'(ls_pulses - b_ls), 0);

        // Contention from a fresh reset
        apply_reset();
        b_ls = ls_pulses;
        mem_rdata   = 64'h5555_6666_7777_8888;
        if_req_addr = 64'h8000_0000;
        ls_req_addr = 64'h8000_1000;
        ls_req_wen  = 1'b0;
        run_both(1, 1, 2);
`ifdef ARB_RR_EN
        if (gq.size() == 2) begin
            chk("b_first_grant", 64'(gq[0]), 0);
            chk("b_second_grant", 64'(gq[1]), 1);
        end
`else
        if (gq.size() == 2) begin
            chk("b_first_grant", 64'(gq[0]), 1);
            chk("b_second_grant", 64'(gq[1]), 0);
        end
`endif
        chk("b_ls_read_data", ls_last, 64'h5555_6666_7777_8888);
        chk("b_ls_pulses", 64'(ls_pulses - b_ls), 1);

        // LSU write with a 4-cycle memory stall
        b_ls = ls_pulses; b_hs = mem_hs;
        mem_rdata     = 64'hAAAA_5555_AAAA_5555;
        mem_req_ready = 1'b0;
        ls_req_addr   = 64'h8000_2000;
        ls_req_wen    = 1'b1;
        ls_req_wdata  = 64'h0000_0000_DEAD_BEEF;
        ls_req_wmask  = 8'h0F;
        ls_req_valid  = 1'b1;
        @(posedge clk); #1 ls_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("c_valid_wen", {mem_req_valid, mem_req_wen}, 2'b11);
            chk("c_addr", mem_req_addr, 64'h8000_2000);
            chk("c_wdata", mem_req_wdata, 64'h0000_0000_DEAD_BEEF);
            chk("c_wmask", mem_req_wmask, 8'h0F);
        end
        @(posedge clk); #1 mem_req_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("c_handshakes", 64'(mem_hs - b_hs), 1);
        chk("c_ls_pulses", 64'(ls_pulses - b_ls), 1);
        chk("c_ls_write_data", ls_last, 0);
        ls_req_wen = 1'b0;

        // Spurious memory response while idle
        b_if = if_pulses; b_ls = ls_pulses;
        man_resp = 1'b1;
        @(posedge clk); #1 man_resp = 1'b0;
        chk("d_no_pulse", {if_resp_valid, ls_resp_valid}, 0);
        @(posedge clk); #1;
        chk("d_mem_valid", mem_req_valid, 0);
        if_req_addr  = 64'h8000_0010;
        if_req_valid = 1'b1;
        #1;
        chk("d_still_idle", if_req_ready, 1);
        @(posedge clk); #1 if_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("d_if_pulses", 64'(if_pulses - b_if), 1);
        chk("d_ls_pulses", 64'(ls_pulses - b_ls), 0);

        // Reset while waiting, then a late response after release
        b_if = if_pulses; b_ls = ls_pulses;
        auto_en      = 1'b0;
        if_req_addr  = 64'h8000_0008;
        if_req_valid = 1'b1;
        @(posedge clk); #1 if_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("e_in_wait", mem_req_valid, 0);
        reset_n = 1'b0;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        #1;
        chk("e_rst_ready", {if_req_ready, ls_req_ready}, 0);
        chk("e_rst_valids", {mem_req_valid, if_resp_valid, ls_resp_valid}, 0);
        chk("e_rst_addr", mem_req_addr, 0);
        chk("e_rst_wdata", mem_req_wdata, 0);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        reset_n = 1'b1;
        auto_en = 1'b1;
        @(posedge clk); #1 man_resp = 1'b1;
        @(posedge clk); #1 man_resp = 1'b0;
        chk("e_late_no_pulse", {if_resp_valid, ls_resp_valid}, 0);
        @(posedge clk); #1;
        chk("e_after_quiet", {mem_req_valid, if_resp_valid, ls_resp_valid}, 0);
        chk("e_pulse_total", 64'(if_pulses - b_if + ls_pulses - b_ls), 0);

        // Ten back-to-back contended transactions
        apply_reset();
        run_both(10, 10, 10);
        for (int i = 0; i < 10 && i < gq.size(); i++) begin
`ifdef ARB_RR_EN
            chk("f_grant", 64'(gq[i]), 64'(i % 2));
`else
            chk("f_grant", 64'(gq[i]), 1);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
